// File: rtl/vga_sync.sv
// 640x480@60 raster timing generator: pixel-rate divider, h/v counters and registered sync/blank decode.
// Optional frame counter enabled by defining VGA_SYNC_FRAME_CNT_EN; otherwise frame_cnt is tied to 0.
module vga_sync #(
  parameter int CLK_DIV   = 4,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk_d,
  input  logic       rst_n,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       p_tick,
  output logic       frame_start,
  output logic [7:0] frame_cnt
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_DISP   = 10'(H_DISPLAY);
  localparam logic [9:0] V_DISP   = 10'(V_DISPLAY);
  localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [9:0]       h_cnt, v_cnt;
  logic             tick, h_last, v_last;

  assign tick   = (div_cnt == DIV_LAST);
  assign h_last = (h_cnt == H_LAST);
  assign v_last = (v_cnt == V_LAST);

  // Pixel-rate divider; with CLK_DIV=1 it stays at 0 and tick is permanently high.
  always_ff @(posedge clk_d) begin
    if (!rst_n)    div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + DIV_W'(1);
  end

  always_ff @(posedge clk_d) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (tick) begin
      h_cnt <= h_last ? 10'd0 : h_cnt + 10'd1;
      if (h_last) v_cnt <= v_last ? 10'd0 : v_cnt + 10'd1;
    end
  end

  // Every output is decoded from the same counter snapshot, so they stay mutually aligned.
  always_ff @(posedge clk_d) begin
    if (!rst_n) begin
      pixel_x     <= '0;
      pixel_y     <= '0;
      video_on    <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      p_tick      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pixel_x     <= h_cnt;
      pixel_y     <= v_cnt;
      video_on    <= (h_cnt < H_DISP) && (v_cnt < V_DISP);
      hsync       <= !((h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST));
      vsync       <= !((v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST));
      p_tick      <= tick;
      // div_cnt==0 marks the first cycle a counter value is presented, incl. right after reset.
      frame_start <= (h_cnt == 10'd0) && (v_cnt == 10'd0) && (div_cnt == '0);
    end
  end

`ifdef VGA_SYNC_FRAME_CNT_EN
  logic wrap_q;

  // wrap_q lines the increment up with the cycle the outputs show the wrapped (0,0).
  always_ff @(posedge clk_d) begin
    if (!rst_n) begin
      wrap_q    <= 1'b0;
      frame_cnt <= '0;
    end else begin
      wrap_q <= tick && h_last && v_last;
      if (wrap_q) frame_cnt <= frame_cnt + 8'd1;
    end
  end
`else
  assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_sync.sv
// Self-checking bench for vga_sync: arithmetic raster model on three configurations plus literal spot checks.
module tb_vga_sync;

`ifdef VGA_SYNC_FRAME_CNT_EN
  localparam bit FC_EN = 1'b1;
`else
  localparam bit FC_EN = 1'b0;
`endif

  typedef struct {
    int x, y, von, hs, vs, pt, fs, fc;
  } exp_t;

  logic clk_d = 1'b0;
  always #5 clk_d = ~clk_d;

  logic rst_a = 1'b0, rst_b = 1'b0, rst_c = 1'b0;

  logic [9:0] ax, ay, bx, by, cx, cy;
  logic       av, ahs, avs, apt, afs;
  logic       bv, bhs, bvs, bpt, bfs;
  logic       cv, chs, cvs, cpt, cfs;
  logic [7:0] afc, bfc, cfc;

  // A: default 640x480 timing; B: small raster for full frames; C: CLK_DIV=1 tiny raster for frame_cnt wrap.
  vga_sync #(.CLK_DIV(4)) u_a (
    .clk_d(clk_d), .rst_n(rst_a), .pixel_x(ax), .pixel_y(ay), .video_on(av),
    .hsync(ahs), .vsync(avs), .p_tick(apt), .frame_start(afs), .frame_cnt(afc));

  vga_sync #(.CLK_DIV(4), .H_DISPLAY(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(6),
             .V_DISPLAY(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(4)) u_b (
    .clk_d(clk_d), .rst_n(rst_b), .pixel_x(bx), .pixel_y(by), .video_on(bv),
    .hsync(bhs), .vsync(bvs), .p_tick(bpt), .frame_start(bfs), .frame_cnt(bfc));

  vga_sync #(.CLK_DIV(1), .H_DISPLAY(2), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
             .V_DISPLAY(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)) u_c (
    .clk_d(clk_d), .rst_n(rst_c), .pixel_x(cx), .pixel_y(cy), .video_on(cv),
    .hsync(chs), .vsync(cvs), .p_tick(cpt), .frame_start(cfs), .frame_cnt(cfc));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // t = clk_d edges since the first edge with reset released (t=0 at E0), -1 while in reset.
  function automatic exp_t model(input int t, input int cd, input int hd, input int hf,
                                 input int hsn, input int hb, input int vd, input int vf,
                                 input int vsn, input int vb);
    exp_t e;
    int ht, vt, n, p;
    e = '{x:0, y:0, von:0, hs:1, vs:1, pt:0, fs:0, fc:0};
    if (t >= 0) begin
      ht = hd + hf + hsn + hb;
      vt = vd + vf + vsn + vb;
      n  = t / cd;
      p  = n % (ht * vt);
      e.x   = p % ht;
      e.y   = p / ht;
      e.von = (e.x < hd && e.y < vd) ? 1 : 0;
      e.hs  = (e.x >= hd + hf && e.x < hd + hf + hsn) ? 0 : 1;
      e.vs  = (e.y >= vd + vf && e.y < vd + vf + vsn) ? 0 : 1;
      e.pt  = ((t % cd) == cd - 1) ? 1 : 0;
      e.fs  = (p == 0 && (t % cd) == 0) ? 1 : 0;
      e.fc  = FC_EN ? (n / (ht * vt)) % 256 : 0;
    end
    return e;
  endfunction

  task automatic chk_inst(input string nm, input exp_t e, input logic [9:0] x, input logic [9:0] y,
                          input logic v, input logic hs, input logic vs, input logic pt,
                          input logic fs, input logic [7:0] fc);
    chk({nm, ".pixel_x"}, int'(x), e.x);
    chk({nm, ".pixel_y"}, int'(y), e.y);
    chk({nm, ".video_on"}, int'(v), e.von);
    chk({nm, ".hsync"}, int'(hs), e.hs);
    chk({nm, ".vsync"}, int'(vs), e.vs);
    chk({nm, ".p_tick"}, int'(pt), e.pt);
    chk({nm, ".frame_start"}, int'(fs), e.fs);
    chk({nm, ".frame_cnt"}, int'(fc), e.fc);
  endtask

  int ta = -1, tbb = -1, tc = -1;

  always begin
    @(posedge clk_d);
    ta  = rst_a ? ta + 1 : -1;
    tbb = rst_b ? tbb + 1 : -1;
    tc  = rst_c ? tc + 1 : -1;
    #1;
    chk_inst("A", model(ta, 4, 640, 16, 96, 48, 480, 10, 2, 33), ax, ay, av, ahs, avs, apt, afs, afc);
    chk_inst("B", model(tbb, 4, 16, 4, 6, 6, 12, 2, 2, 4), bx, by, bv, bhs, bvs, bpt, bfs, bfc);
    chk_inst("C", model(tc, 1, 2, 1, 1, 1, 2, 1, 1, 1), cx, cy, cv, chs, cvs, cpt, cfs, cfc);
  end

  initial begin
    int hs_low, last_fs, nfs, k;
    hs_low = 0; last_fs = -1; nfs = 0;

    repeat (5) @(negedge clk_d);
    chk("rst_hsync", int'(ahs), 1);
    chk("rst_vsync", int'(avs), 1);
    chk("rst_video_on", int'(av), 0);
    chk("rst_pixel_x", int'(ax), 0);
    chk("rst_pixel_y", int'(ay), 0);
    chk("rst_p_tick", int'(apt), 0);
    chk("rst_c_p_tick", int'(cpt), 0);

    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;

    for (int i = 0; i < 6500; i++) begin
      @(posedge clk_d); #1;
      if (i == 0) begin
        chk("e0_x", int'(ax), 0);
        chk("e0_y", int'(ay), 0);
        chk("e0_video_on", int'(av), 1);
        chk("e0_frame_start", int'(afs), 1);
      end
      if (i == 1) chk("e1_frame_start", int'(afs), 0);
      if (i == 2) chk("e2_p_tick", int'(apt), 0);
      if (i == 3) chk("e3_p_tick", int'(apt), 1);
      if (i == 4) begin
        chk("e4_x", int'(ax), 1);
        chk("e4_p_tick", int'(apt), 0);
      end
      if (i == 3199) chk("a_x799", int'(ax), 799);
      if (i == 3200) begin
        chk("a_line_wrap_x", int'(ax), 0);
        chk("a_line_wrap_y", int'(ay), 1);
      end
      if (i < 6400 && !ahs) hs_low++;
      if (bfs) begin
        if (last_fs >= 0) chk("b_frame_gap", i - last_fs, 2560);
        last_fs = i;
        nfs++;
      end
      if (i == 6399) chk("c_fc_255", int'(cfc), FC_EN ? 255 : 0);
      if (i == 6424) chk("c_fc_pre_wrap", int'(cfc), 0);
      if (i == 6425) begin
        chk("c_fc_257", int'(cfc), FC_EN ? 1 : 0);
        chk("c_fs_257", int'(cfs), 1);
      end
    end
    chk("a_hsync_low_cycles", hs_low, 768);
    chk("b_frame_starts", nfs, 3);

    // Mid-frame reset on B.
    k = 0;
    while (by != 10'd10 && k < 5000) begin
      @(negedge clk_d);
      k++;
    end
    chk("b_wait_y10", int'(by), 10);
    rst_b = 1'b0;
    @(posedge clk_d); #1;
    chk("b_mid_rst_x", int'(bx), 0);
    chk("b_mid_rst_y", int'(by), 0);
    chk("b_mid_rst_video_on", int'(bv), 0);
    chk("b_mid_rst_hsync", int'(bhs), 1);
    chk("b_mid_rst_frame_start", int'(bfs), 0);
    repeat (2) @(negedge clk_d);
    rst_b = 1'b1;
    @(posedge clk_d); #1;
    chk("b_rel_x", int'(bx), 0);
    chk("b_rel_y", int'(by), 0);
    chk("b_rel_video_on", int'(bv), 1);
    chk("b_rel_frame_start", int'(bfs), 1);
    repeat (3000) @(negedge clk_d);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vga_sync.md
# vga_sync

Raster timing generator that drives the pixel generator stage. From the board clock `clk_d` it derives a pixel-rate enable and runs horizontal/vertical counters for 640x480@60 timing. It produces `pixel_x`, `pixel_y`, `video_on` and active-low `hsync`/`vsync`, all registered and mutually aligned. `pixel_x`, `pixel_y` and `video_on` feed the pixel generator directly; `hsync`/`vsync` go to the VGA connector.

## Interface
- `CLK_DIV`, 4: `clk_d` cycles per pixel; legal range ≥1 (4 gives 25 MHz pixels from 100 MHz).
- `H_DISPLAY`, 640; `H_FRONT`, 16; `H_SYNC`, 96; `H_BACK`, 48: horizontal segments in pixels.
- `V_DISPLAY`, 480; `V_FRONT`, 10; `V_SYNC`, 2; `V_BACK`, 33: vertical segments in lines.
- Constraint: H total (800) and V total (525) must each be ≤1024, so counters fit in 10 bits.

Ports:
- `clk_d`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  **one clock; reset is synchronous and active-low.**
- `pixel_x`  out  10  registered column index, 0..H_total-1.
- `pixel_y`  out  10  registered row index, 0..V_total-1.
- `video_on`  out  1  high iff `pixel_x`<H_DISPLAY and `pixel_y`<V_DISPLAY.
- `hsync`  out  1  active-low; low iff `pixel_x` is in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1], i.e. 656..751.
- `vsync`  out  1  active-low; low iff `pixel_y` is in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1], i.e. 490..491.
- `p_tick`  out  1  one-`clk_d` pulse per pixel period.
- `frame_start`  out  1  one-`clk_d` pulse in the first cycle in which the outputs show (0,0).
- `frame_cnt`  out  8  frame counter; exists only when the configuration macro is defined (see Configuration).

## Operation
- **Divider.** `div_cnt` counts 0..CLK_DIV-1 every cycle, then wraps to 0. The internal counters advance on the edge where `div_cnt`==CLK_DIV-1.
- **Horizontal counter.** `h_cnt` increments; at H_total-1 (799) it wraps to 0.
- **Vertical counter.** `v_cnt` increments when `h_cnt` wraps; at V_total-1 (524) it wraps to 0 on the same edge.
- **Output stage.** Every `clk_d` edge registers `h_cnt` and `v_cnt` into `pixel_x`/`pixel_y`. The same edge registers `video_on`, `hsync` and `vsync`, decoded from those same counter values. All five outputs are therefore always mutually consistent.
- **`p_tick`.** Register of (`div_cnt`==CLK_DIV-1). It is high in the cycle before the outputs show the next pixel. With CLK_DIV=1, `p_tick` is constantly 1 after the first cycle out of reset.
- **`frame_start`.** Registered; high in the cycle in which the outputs first show (0,0). This includes the first cycle after reset release.
- **No other states.** The block is free-running. It has no enable, no stall and no handshake; downstream must accept every pixel.

## Timing
- **Reset values** (while `rst_n`=0 is sampled): `div_cnt`=0, `h_cnt`=`v_cnt`=0, `pixel_x`=`pixel_y`=0, `video_on`=0, `hsync`=1, `vsync`=1, `p_tick`=0, `frame_start`=0, `frame_cnt`=0.
- **Edge E0** (first edge with `rst_n`=1): outputs show (0,0), `video_on`=1, `frame_start`=1.
- **Edge E(CLK_DIV-1):** `p_tick` goes to 1.
- **Edge E(CLK_DIV):** `pixel_x`=1 and `p_tick` returns to 0. Every pixel, including the first, is held exactly CLK_DIV cycles.
- **Latency:** outputs lag the internal counters by 1 `clk_d`.
- **Periods:** line = 800·CLK_DIV cycles; frame = 420000·CLK_DIV cycles.
- **Mid-frame reset:** takes effect at the next edge. Outputs return to their reset values; the frame restarts at (0,0) after release.

## Configuration
- **`VGA_SYNC_FRAME_CNT_EN` defined:** `frame_cnt` increments by 1 on each output wrap from (799,524) to (0,0). It wraps 255→0. It does not increment on the first (0,0) after reset.
- **Not defined:** `frame_cnt` is tied to 0 and the counter logic is absent.

## Test plan
- **Reset:** hold `rst_n`=0 for 5 cycles -> `hsync`=`vsync`=1, `video_on`=0, `pixel_x`=`pixel_y`=0, `p_tick`=0.
- **Release (CLK_DIV=4):** after E0 -> (0,0), `video_on`=1, `frame_start`=1 for one cycle. `p_tick` is high only in the cycle after E3. `pixel_x`=1 after E4.
- **Line sweep:** `hsync`=0 exactly for `pixel_x` 656..751. `video_on` falls when `pixel_x` reaches 640. At 799→0, `pixel_y` increments in the same cycle.
- **Frame sweep:** `vsync`=0 only for `pixel_y` 490..491. Wrap (799,524)→(0,0) raises `frame_start` for 1 cycle. Consecutive `frame_start` pulses are 1,680,000 cycles apart.
- **Mid-frame reset:** assert `rst_n`=0 at `pixel_y`=200 -> outputs return to reset values on the next edge. After release, (0,0) and `frame_start` recur as in the release scenario.
- **Macro:** with `VGA_SYNC_FRAME_CNT_EN` and CLK_DIV=1, run 257 frames -> `frame_cnt` reads 1 after the 257th wrap. Without the macro, `frame_cnt` stays 0 throughout.
